// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline write-back slice: register indices,
// write-back select encodings, FSM state type and the MEM/WB register layout.
package pipe_pkg;

  localparam int          XLEN   = 32;
  localparam logic [3:0]  PC_REG = 4'd15;
  localparam logic        WB_ALU = 1'b0;
  localparam logic        WB_MEM = 1'b1;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic            v;
    logic            we;
    logic [3:0]      a3;
    logic [XLEN-1:0] data;
  } mem_wb_t;

endpackage

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register. A non-latching cycle inserts a bubble: v and we
// clear while a3/data keep their previous contents.
module pipe_mem_wb
  import pipe_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            i_latch,
  input  logic            i_we,
  input  logic [3:0]      i_a3,
  input  logic [XLEN-1:0] i_data,
  output logic            o_v,
  output logic            o_we,
  output logic [3:0]      o_a3,
  output logic [XLEN-1:0] o_data
);

  mem_wb_t r_wb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wb <= '0;
    end else if (i_latch) begin
      r_wb.v    <= 1'b1;
      r_wb.we   <= i_we;
      r_wb.a3   <= i_a3;
      r_wb.data <= i_data;
    end else begin
      r_wb.v  <= 1'b0;
      r_wb.we <= 1'b0;
    end
  end

  assign o_v    = r_wb.v;
  assign o_we   = r_wb.we;
  assign o_a3   = r_wb.a3;
  assign o_data = r_wb.data;

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: drives the register-file write port, same-cycle bypass
// flags, R15 redirects, load-wait stall/timeout and the retired counter.
module stage_wb
  import pipe_pkg::*;
#(
  parameter int N            = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         valid_mem,
  input  logic         RF_WE_mem,
  input  logic [3:0]   A3_mem,
  input  logic         WBSelect_mem,
  input  logic [N-1:0] ALUResult_mem,
  input  logic [N-1:0] ReadData_mem,
  input  logic         ReadData_valid_mem,
  input  logic         flush_i,
  input  logic [3:0]   A1_id,
  input  logic [3:0]   A2_id,
  output logic         RF_WE_wb,
  output logic [3:0]   A3_wb,
  output logic [N-1:0] wb_data_wb,
  output logic         fwd_A1_o,
  output logic         fwd_A2_o,
  output logic         stall_mem_o,
  output logic         pc_redirect_o,
  output logic [N-1:0] pc_target_o,
  output logic         load_error_o,
  output logic [31:0]  retired_count_o,
  output logic         dbg_state_o
);

  localparam int            CW        = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(LOAD_TIMEOUT);

  wb_state_t     r_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_load_error;
  logic [31:0]   r_retired;
  logic [N-1:0]  r_pc_target;

  logic          w_stall;
  logic          w_latch;
  logic [N-1:0]  w_sel_data;
  logic          w_v;
  logic          w_we;
  logic [3:0]    w_a3;
  logic [N-1:0]  w_data;
  logic          w_is_pc;
  logic [CW-1:0] w_cnt_next;

  // Flush masks the stall, so a squashed load never holds MEM.
  assign w_stall    = valid_mem & (WBSelect_mem == WB_MEM) & ~ReadData_valid_mem & ~flush_i;
  assign w_latch    = valid_mem & ~flush_i & ~w_stall;
  assign w_sel_data = (WBSelect_mem == WB_MEM) ? ReadData_mem : ALUResult_mem;

  pipe_mem_wb u_mem_wb (
    .CLK     (CLK),
    .RST     (RST),
    .i_latch (w_latch),
    .i_we    (RF_WE_mem),
    .i_a3    (A3_mem),
    .i_data  (w_sel_data),
    .o_v     (w_v),
    .o_we    (w_we),
    .o_a3    (w_a3),
    .o_data  (w_data)
  );

  assign w_is_pc  = w_v & w_we & (w_a3 == PC_REG);
  assign RF_WE_wb = w_v & w_we & (w_a3 != PC_REG);
  assign A3_wb      = w_a3;
  assign wb_data_wb = w_data;

  assign fwd_A1_o = RF_WE_wb & (w_a3 == A1_id);
  assign fwd_A2_o = RF_WE_wb & (w_a3 == A2_id);

  assign stall_mem_o   = w_stall;
  assign pc_redirect_o = w_is_pc;
  assign pc_target_o   = w_is_pc ? w_data : r_pc_target;

  assign load_error_o    = r_load_error;
  assign retired_count_o = r_retired;
  assign dbg_state_o     = r_state;

  // Counter saturates so a stuck load cannot wrap back below the timeout.
  assign w_cnt_next = (r_state == IDLE)         ? CW'(1) :
                      (r_wait_cnt == TIMEOUT_C) ? r_wait_cnt :
                                                  r_wait_cnt + CW'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_wait_cnt   <= '0;
      r_load_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stall) begin
            r_state    <= WAIT_LOAD;
            r_wait_cnt <= w_cnt_next;
            if (w_cnt_next == TIMEOUT_C) r_load_error <= 1'b1;
          end
        end
        WAIT_LOAD: begin
          if (!w_stall) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_cnt_next;
            if (w_cnt_next == TIMEOUT_C) r_load_error <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_retired   <= '0;
      r_pc_target <= '0;
    end else begin
      if (w_latch) r_retired <= r_retired + 32'd1;
      if (w_is_pc) r_pc_target <= w_data;
    end
  end

endmodule
